// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN frame sequencer.
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        WAIT_BYTE,
        START,
        CORE_WAIT,
        TX
    } frame_state_t;

    function automatic int words_per_byte(input int ram_dw);
        return 8 / ram_dw;
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Splits one received byte into RAM_DW-wide RAM words, LSB first, one word per cycle.
module byte_unpacker
    import snn_pkg::*;
#(
    parameter int RAM_DW = 1,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              first,
    input  logic [7:0]        din,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_data,
    output logic              done
);

    localparam int WPB = words_per_byte(RAM_DW);
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;

    logic [7:0]    shreg;
    logic [CW-1:0] words_left;

    // done marks the cycle carrying the last word of the byte
    assign done = ram_we && (words_left == '0);

    // ram_addr always points at the word being (or last) written, so it never runs past WORDS-1
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            shreg      <= '0;
            words_left <= '0;
        end else if (load) begin
            ram_we     <= 1'b1;
            ram_data   <= din[RAM_DW-1:0];
            shreg      <= din >> RAM_DW;
            words_left <= CW'(WPB - 1);
            ram_addr   <= first ? '0 : ram_addr + RAM_AW'(1);
        end else if (ram_we && !done) begin
            ram_data   <= shreg[RAM_DW-1:0];
            shreg      <= shreg >> RAM_DW;
            words_left <= words_left - CW'(1);
            ram_addr   <= ram_addr + RAM_AW'(1);
        end else begin
            ram_we <= 1'b0;
        end
    end

endmodule

// File: rtl/snn_frame_ctrl.sv
// Frame sequencer: UART RX bytes -> SNN input RAM -> snn_core -> one UART TX result byte.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for the first byte of a frame
// UNPACK    | writing the current byte into RAM, one word per cycle
// WAIT_BYTE | waiting for the next byte, gap timer running
// START     | core_start pulse
// CORE_WAIT | waiting for core_done, result latched on it
// TX        | waiting for tx_rdy, result byte launched on it
module snn_frame_ctrl
    import snn_pkg::*;
#(
    parameter int FRAME_BYTES = 98,
    parameter int RAM_DW      = 1,
    parameter int RAM_AW      = 10,
    parameter int RESULT_W    = 4,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_rdy,
    input  logic [7:0]          rx_data,
    output logic                ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [RAM_DW-1:0]   ram_data,
    output logic                core_start,
    input  logic                core_done,
    input  logic [RESULT_W-1:0] core_result,
    input  logic                tx_rdy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                frame_err,
    output logic                overrun
);

    localparam int BW = $clog2(FRAME_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    frame_state_t  state;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    tx_byte;
    logic [7:0]    tx_hold;
    logic          load;
    logic          unpack_done;

    assign load     = rx_rdy && (state == IDLE || state == WAIT_BYTE);
    assign busy     = (state != IDLE);
    assign tx_start = (state == TX) && tx_rdy;
    assign tx_data  = tx_start ? tx_byte : tx_hold;

    always_comb begin
        tx_byte                 = '0;
        tx_byte[RESULT_W-1:0]   = result;
    end

    byte_unpacker #(
        .RAM_DW (RAM_DW),
        .RAM_AW (RAM_AW)
    ) u_unpack (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .first    (state == IDLE),
        .din      (rx_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .done     (unpack_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            result     <= '0;
            tx_hold    <= '0;
        end else begin
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            // a byte arriving while a frame is being processed is dropped
            if (rx_rdy && !load)
                overrun <= 1'b1;
            if (tx_start)
                tx_hold <= tx_byte;

            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        byte_cnt <= BW'(1);
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (unpack_done) begin
                        if (byte_cnt == BW'(FRAME_BYTES)) begin
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                            state   <= WAIT_BYTE;
                        end
                    end
                end
                WAIT_BYTE: begin
                    // an arriving byte beats a coincident gap expiry
                    if (rx_rdy) begin
                        byte_cnt <= byte_cnt + BW'(1);
                        state    <= UNPACK;
                    end else if (gap_cnt == '0) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                START: begin
                    state <= CORE_WAIT;
                end
                CORE_WAIT: begin
                    if (core_done) begin
                        result <= core_result;
                        state  <= TX;
                    end
                end
                TX: begin
                    if (tx_rdy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Directed bench for snn_frame_ctrl: three parameterisations sharing one clock and reset.
module tb_snn_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       core_done = 1'b0;
    logic [3:0] core_result = 4'h0;
    logic       tx_rdy = 1'b0;
    int         sel = 0;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance a: defaults, b: 4-bit words / 2-byte frames, c: short gap
    logic       a_rx_rdy, b_rx_rdy, c_rx_rdy;
    assign a_rx_rdy = rx_rdy && (sel == 0);
    assign b_rx_rdy = rx_rdy && (sel == 1);
    assign c_rx_rdy = rx_rdy && (sel == 2);

    logic       a_ram_we, a_core_start, a_tx_start, a_busy, a_frame_err, a_overrun;
    logic [9:0] a_ram_addr;
    logic [0:0] a_ram_data;
    logic [7:0] a_tx_data;
    logic [3:0] a_result;

    logic       b_ram_we, b_core_start, b_tx_start, b_busy, b_frame_err, b_overrun;
    logic [9:0] b_ram_addr;
    logic [3:0] b_ram_data;
    logic [7:0] b_tx_data;
    logic [3:0] b_result;

    logic       c_ram_we, c_core_start, c_tx_start, c_busy, c_frame_err, c_overrun;
    logic [9:0] c_ram_addr;
    logic [0:0] c_ram_data;
    logic [7:0] c_tx_data;
    logic [3:0] c_result;

    snn_frame_ctrl u_a (
        .clk(clk), .rst(rst), .rx_rdy(a_rx_rdy), .rx_data(rx_data),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_data(a_ram_data),
        .core_start(a_core_start), .core_done(core_done), .core_result(core_result),
        .tx_rdy(tx_rdy), .tx_start(a_tx_start), .tx_data(a_tx_data), .result(a_result),
        .busy(a_busy), .frame_err(a_frame_err), .overrun(a_overrun)
    );

    snn_frame_ctrl #(.FRAME_BYTES(2), .RAM_DW(4)) u_b (
        .clk(clk), .rst(rst), .rx_rdy(b_rx_rdy), .rx_data(rx_data),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
        .core_start(b_core_start), .core_done(core_done), .core_result(core_result),
        .tx_rdy(tx_rdy), .tx_start(b_tx_start), .tx_data(b_tx_data), .result(b_result),
        .busy(b_busy), .frame_err(b_frame_err), .overrun(b_overrun)
    );

    snn_frame_ctrl #(.GAP_CYCLES(100)) u_c (
        .clk(clk), .rst(rst), .rx_rdy(c_rx_rdy), .rx_data(rx_data),
        .ram_we(c_ram_we), .ram_addr(c_ram_addr), .ram_data(c_ram_data),
        .core_start(c_core_start), .core_done(core_done), .core_result(core_result),
        .tx_rdy(tx_rdy), .tx_start(c_tx_start), .tx_data(c_tx_data), .result(c_result),
        .busy(c_busy), .frame_err(c_frame_err), .overrun(c_overrun)
    );

    // negedge monitors; frames for a and c always carry 0x01 bytes, so bit 1 lands on addr%8==0
    int a_wr_cnt = 0, a_fw = 0, a_order_err = 0, a_data_err = 0, a_last_wcyc = 0, a_last_waddr = 0;
    int a_cs_cnt = 0, a_cs_cyc = 0, a_tx_cnt = 0, a_tx_cyc = 0, a_tx_val = 0, a_ferr_cnt = 0;
    int c_wr_cnt = 0, c_fw = 0, c_order_err = 0, c_data_err = 0, c_last_wcyc = 0;
    int c_cs_cnt = 0, c_tx_cnt = 0, c_tx_val = 0, c_ferr_cnt = 0, c_ferr_cyc = 0;
    int b_wr_cnt = 0, b_cs_cnt = 0, b_cs_cyc = 0, b_tx_cnt = 0, b_tx_val = 0, b_ferr_cnt = 0;
    logic [9:0] b_log_addr [8];
    logic [3:0] b_log_data [8];
    int         b_log_cyc  [8];

    always @(negedge clk) begin
        if (a_ram_we) begin
            a_wr_cnt     <= a_wr_cnt + 1;
            a_fw         <= a_fw + 1;
            a_last_wcyc  <= cyc;
            a_last_waddr <= int'(a_ram_addr);
            if (int'(a_ram_addr) != a_fw) a_order_err <= a_order_err + 1;
            if (a_ram_data[0] != (a_ram_addr[2:0] == 3'd0)) a_data_err <= a_data_err + 1;
        end else if (!a_busy) begin
            a_fw <= 0;
        end
        if (a_core_start) begin a_cs_cnt <= a_cs_cnt + 1; a_cs_cyc <= cyc; end
        if (a_tx_start) begin a_tx_cnt <= a_tx_cnt + 1; a_tx_cyc <= cyc; a_tx_val <= int'(a_tx_data); end
        if (a_frame_err) a_ferr_cnt <= a_ferr_cnt + 1;
    end

    always @(negedge clk) begin
        if (c_ram_we) begin
            c_wr_cnt    <= c_wr_cnt + 1;
            c_fw        <= c_fw + 1;
            c_last_wcyc <= cyc;
            if (int'(c_ram_addr) != c_fw) c_order_err <= c_order_err + 1;
            if (c_ram_data[0] != (c_ram_addr[2:0] == 3'd0)) c_data_err <= c_data_err + 1;
        end else if (!c_busy) begin
            c_fw <= 0;
        end
        if (c_core_start) c_cs_cnt <= c_cs_cnt + 1;
        if (c_tx_start) begin c_tx_cnt <= c_tx_cnt + 1; c_tx_val <= int'(c_tx_data); end
        if (c_frame_err) begin c_ferr_cnt <= c_ferr_cnt + 1; c_ferr_cyc <= cyc; end
    end

    always @(negedge clk) begin
        if (b_ram_we) begin
            if (b_wr_cnt < 8) begin
                b_log_addr[b_wr_cnt] <= b_ram_addr;
                b_log_data[b_wr_cnt] <= b_ram_data;
                b_log_cyc[b_wr_cnt]  <= cyc;
            end
            b_wr_cnt <= b_wr_cnt + 1;
        end
        if (b_core_start) begin b_cs_cnt <= b_cs_cnt + 1; b_cs_cyc <= cyc; end
        if (b_tx_start) begin b_tx_cnt <= b_tx_cnt + 1; b_tx_val <= int'(b_tx_data); end
        if (b_frame_err) b_ferr_cnt <= b_ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int last_rx_cyc = 0;

    task automatic send(input logic [7:0] b, input int gap);
        rx_data     = b;
        rx_rdy      = 1'b1;
        last_rx_cyc = cyc;
        tick(1);
        rx_rdy = 1'b0;
        tick(gap);
    endtask

    logic [9:0] exp_addr [4];
    logic [3:0] exp_data [4];
    int         n0;
    int         rdy_cyc;

    initial begin
        exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3};
        exp_data = '{4'h5, 4'hA, 4'hC, 4'h3};

        // reset state
        tick(3);
        chk("rst_ram_we", a_ram_we, 0);
        chk("rst_ram_addr", a_ram_addr, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_overrun", a_overrun, 0);
        chk("rst_result", a_result, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_core_start", a_core_start, 0);
        rst = 1'b0;
        tick(2);

        // full default frame of 0x01 bytes, core answers 7, transmitter busy 200 cycles
        sel = 0;
        for (int i = 0; i < 97; i++) send(8'h01, 19);
        send(8'h01, 0);
        for (int i = 0; i < 30 && a_cs_cnt == 0; i++) tick(1);
        chk("a_core_start_cnt", a_cs_cnt, 1);
        chk("a_writes", a_wr_cnt, 784);
        chk("a_last_addr", a_last_waddr, 783);
        chk("a_addr_order_err", a_order_err, 0);
        chk("a_data_err", a_data_err, 0);
        chk("a_start_after_last_write", a_cs_cyc, a_last_wcyc + 1);
        tick(50);
        core_done   = 1'b1;
        core_result = 4'd7;
        tick(1);
        core_done = 1'b0;
        tick(200);
        chk("a_result_latched", a_result, 7);
        chk("a_no_tx_while_busy_tx", a_tx_cnt, 0);
        chk("a_busy_in_tx", a_busy, 1);
        tx_rdy  = 1'b1;
        rdy_cyc = cyc;
        tick(5);
        chk("a_tx_cnt", a_tx_cnt, 1);
        chk("a_tx_cycle", a_tx_cyc, rdy_cyc);
        chk("a_tx_val", a_tx_val, 7);
        chk("a_tx_data_hold", a_tx_data, 8'h07);
        chk("a_idle_after_tx", a_busy, 0);
        chk("a_overrun_clean", a_overrun, 0);
        chk("a_no_frame_err", a_ferr_cnt, 0);

        // 4-bit words, two-byte frame
        sel = 1;
        send(8'hA5, 4);
        n0 = last_rx_cyc;
        send(8'h3C, 0);
        for (int i = 0; i < 20 && b_cs_cnt == 0; i++) tick(1);
        chk("b_core_start_cnt", b_cs_cnt, 1);
        chk("b_writes", b_wr_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_addr%0d", i), b_log_addr[i], exp_addr[i]);
            chk($sformatf("b_data%0d", i), b_log_data[i], exp_data[i]);
        end
        chk("b_first_write_cycle", b_log_cyc[0], n0 + 1);
        chk("b_last_word_cycle", b_log_cyc[1], n0 + 2);
        chk("b_start_after_last_write", b_cs_cyc, b_log_cyc[3] + 1);
        core_done   = 1'b1;
        core_result = 4'd3;
        tick(1);
        core_done = 1'b0;
        tick(3);
        chk("b_tx_cnt", b_tx_cnt, 1);
        chk("b_tx_val", b_tx_val, 3);
        chk("b_result", b_result, 3);
        chk("b_idle", b_busy, 0);
        chk("b_overrun_clean", b_overrun, 0);
        chk("b_no_frame_err", b_ferr_cnt, 0);

        // gap timeout after 3 bytes, then a clean frame, then a dropped byte in CORE_WAIT
        sel = 2;
        send(8'h01, 19);
        send(8'h01, 19);
        send(8'h01, 0);
        for (int i = 0; i < 300 && c_ferr_cnt == 0; i++) tick(1);
        chk("c_frame_err_cnt", c_ferr_cnt, 1);
        chk("c_frame_err_cycle", c_ferr_cyc, c_last_wcyc + 101);
        tick(3);
        chk("c_frame_err_single", c_ferr_cnt, 1);
        chk("c_idle_after_err", c_busy, 0);
        chk("c_no_core_start", c_cs_cnt, 0);
        n0 = c_wr_cnt;
        for (int i = 0; i < 97; i++) send(8'h01, 19);
        send(8'h01, 0);
        for (int i = 0; i < 30 && c_cs_cnt == 0; i++) tick(1);
        chk("c_core_start_cnt", c_cs_cnt, 1);
        chk("c_writes", c_wr_cnt - n0, 784);
        chk("c_addr_order_err", c_order_err, 0);
        chk("c_data_err", c_data_err, 0);
        chk("c_frame_err_still_1", c_ferr_cnt, 1);
        tick(5);
        send(8'hFF, 2);
        chk("c_overrun_set", c_overrun, 1);
        chk("c_no_write_on_drop", c_wr_cnt - n0, 784);
        core_done   = 1'b1;
        core_result = 4'd9;
        tick(1);
        core_done = 1'b0;
        tick(3);
        chk("c_tx_cnt", c_tx_cnt, 1);
        chk("c_tx_val", c_tx_val, 9);
        chk("c_result", c_result, 9);
        chk("c_overrun_sticky", c_overrun, 1);

        // reset in the middle of unpacking byte 40
        sel = 0;
        for (int i = 0; i < 39; i++) send(8'h01, 19);
        send(8'h01, 0);
        send(8'h01, 0);
        chk("d_pre_we", a_ram_we, 1);
        chk("d_pre_overrun", a_overrun, 1);
        rst = 1'b1;
        tick(1);
        chk("d_ram_we", a_ram_we, 0);
        chk("d_busy", a_busy, 0);
        chk("d_overrun", a_overrun, 0);
        chk("d_ram_addr", a_ram_addr, 0);
        chk("d_ram_data", a_ram_data, 0);
        chk("d_result", a_result, 0);
        chk("d_tx_data", a_tx_data, 0);
        chk("d_tx_start", a_tx_start, 0);
        chk("d_frame_err", a_frame_err, 0);
        chk("d_core_start", a_core_start, 0);
        rst = 1'b0;
        n0 = a_wr_cnt;
        tick(20);
        chk("d_no_writes_after_rst", a_wr_cnt, n0);
        chk("d_no_start_after_rst", a_cs_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
